// File: rtl/neogeo_csync_gen.sv
// Free-running NeoGeo-format timing generator: composite sync plus colour-bar test pattern.
// Define NEOGEO_CSYNC_EQU_EN for equalization/serration pulses; otherwise only the VSYNC lines differ.
module neogeo_csync_gen #(
  parameter int unsigned H_TOTAL     = 384,
  parameter int unsigned H_SYNCLEN   = 29,
  parameter int unsigned H_BACKPORCH = 28,
  parameter int unsigned H_ACTIVE    = 320,
  parameter int unsigned V_TOTAL     = 264,
  parameter int unsigned V_SYNCLEN   = 3,
  parameter int unsigned V_BACKPORCH = 21,
  parameter int unsigned V_ACTIVE    = 224,
  parameter int unsigned EQU_LINES   = 3
) (
  input  logic        VCLK_i,
  input  logic        RST_i,
  input  logic        ENABLE_i,
  output logic        CSYNC_o,
  output logic [4:0]  R_o,
  output logic [4:0]  G_o,
  output logic [4:0]  B_o,
  output logic        DARK_o,
  output logic        SHADOW_o,
  output logic        DE_o,
  output logic [15:0] frame_ctr
);

  localparam int unsigned CW     = 9;
  localparam int unsigned BAR_W  = 40;
  localparam int unsigned H_ACT0 = H_SYNCLEN + H_BACKPORCH;
  localparam int unsigned H_ACT1 = H_ACT0 + H_ACTIVE;
  localparam int unsigned VS0    = EQU_LINES;
  localparam int unsigned VS1    = VS0 + V_SYNCLEN;
  localparam int unsigned V_ACT0 = VS1 + V_BACKPORCH;
  localparam int unsigned V_ACT1 = V_ACT0 + V_ACTIVE;
  localparam int unsigned V_DARK = V_ACT0 + V_ACTIVE / 2;
`ifdef NEOGEO_CSYNC_EQU_EN
  localparam int unsigned HALF   = H_TOTAL / 2;
  localparam int unsigned EQW    = H_SYNCLEN / 2;
  localparam int unsigned POST1  = VS1 + EQU_LINES;
`endif

  logic [CW-1:0] h_ctr;
  logic [CW-1:0] v_ctr;
  logic          run_c;
  logic          h_last_c;
  logic          v_last_c;
  logic          vsync_c;
  logic          sync_low_c;
  logic          de_c;
  logic          dark_c;
  logic [CW-1:0] x_c;
  logic [2:0]    bar_c;

  assign run_c    = ENABLE_i && !RST_i;
  assign h_last_c = (h_ctr == CW'(H_TOTAL - 1));
  assign v_last_c = (v_ctr == CW'(V_TOTAL - 1));

  // Line/frame counters; disable aborts the frame and parks at the origin
  always_ff @(posedge VCLK_i) begin
    if (!run_c) begin
      h_ctr <= '0;
      v_ctr <= '0;
    end else if (h_last_c) begin
      h_ctr <= '0;
      v_ctr <= v_last_c ? '0 : v_ctr + CW'(1);
    end else begin
      h_ctr <= h_ctr + CW'(1);
    end
  end

  // Completed-frame count survives disable, cleared only by reset
  always_ff @(posedge VCLK_i) begin
    if (RST_i) begin
      frame_ctr <= '0;
    end else if (ENABLE_i && h_last_c && v_last_c) begin
      frame_ctr <= frame_ctr + 16'd1;
    end
  end

  assign vsync_c = (v_ctr >= CW'(VS0)) && (v_ctr < CW'(VS1));

  // Composite sync low window for the current line type
  always_comb begin
    sync_low_c = (h_ctr < CW'(H_SYNCLEN));
`ifdef NEOGEO_CSYNC_EQU_EN
    if (vsync_c) begin
      sync_low_c = (h_ctr < CW'(HALF - H_SYNCLEN)) ||
                   ((h_ctr >= CW'(HALF)) && (h_ctr < CW'(H_TOTAL - H_SYNCLEN)));
    end else if ((v_ctr < CW'(VS0)) || ((v_ctr >= CW'(VS1)) && (v_ctr < CW'(POST1)))) begin
      sync_low_c = (h_ctr < CW'(EQW)) ||
                   ((h_ctr >= CW'(HALF)) && (h_ctr < CW'(HALF + EQW)));
    end
`else
    if (vsync_c) begin
      sync_low_c = (h_ctr < CW'(H_TOTAL - H_SYNCLEN));
    end
`endif
  end

  assign de_c   = (h_ctr >= CW'(H_ACT0)) && (h_ctr < CW'(H_ACT1)) &&
                  (v_ctr >= CW'(V_ACT0)) && (v_ctr < CW'(V_ACT1));
  assign dark_c = (v_ctr >= CW'(V_DARK));
  assign x_c    = h_ctr - CW'(H_ACT0);

  // Bar index by threshold chain; descending so the lowest matching threshold wins
  always_comb begin
    bar_c = 3'd7;
    for (int i = 7; i >= 1; i--) begin
      if (x_c < CW'(i * BAR_W)) bar_c = 3'(i - 1);
    end
  end

  // Bars: white, yellow, cyan, green, magenta, red, blue, black
  always_ff @(posedge VCLK_i) begin
    if (!run_c) begin
      CSYNC_o  <= 1'b1;
      R_o      <= '0;
      G_o      <= '0;
      B_o      <= '0;
      DARK_o   <= 1'b0;
      SHADOW_o <= 1'b0;
      DE_o     <= 1'b0;
    end else begin
      CSYNC_o  <= ~sync_low_c;
      R_o      <= (de_c && !bar_c[1]) ? 5'd31 : 5'd0;
      G_o      <= (de_c && !bar_c[2]) ? 5'd31 : 5'd0;
      B_o      <= (de_c && !bar_c[0]) ? 5'd31 : 5'd0;
      DARK_o   <= de_c && dark_c;
      SHADOW_o <= 1'b0;
      DE_o     <= de_c;
    end
  end

endmodule

// File: tb/tb_neogeo_csync_gen.sv
// Directed bench for neogeo_csync_gen; uses a 40-line frame so a whole frame fits the cycle budget.
// Expectations follow NEOGEO_CSYNC_EQU_EN when the bench is built with it.
module tb_neogeo_csync_gen;

  localparam int unsigned HT    = 384;
  localparam int unsigned VT    = 40;
  localparam int unsigned FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        csync;
  logic [4:0]  r, g, b;
  logic        dark, shadow, de;
  logic [15:0] frame_ctr;

  always #5 clk = ~clk;

  neogeo_csync_gen #(
    .V_TOTAL(VT), .V_BACKPORCH(5), .V_ACTIVE(24)
  ) dut (
    .VCLK_i(clk), .RST_i(rst), .ENABLE_i(en), .CSYNC_o(csync),
    .R_o(r), .G_o(g), .B_o(b), .DARK_o(dark), .SHADOW_o(shadow),
    .DE_o(de), .frame_ctr(frame_ctr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic       cs_a [FRAME];
  logic       de_a [FRAME];
  logic       dk_a [FRAME];
  logic [14:0] rgb_a [FRAME];
  int unsigned sh_cnt, edges, de_total, de_lines, cnt;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned idx(input int unsigned v, input int unsigned h);
    return v * HT + h;
  endfunction

  function automatic int unsigned low_in_line(input int unsigned v);
    int unsigned c = 0;
    for (int h = 0; h < HT; h++) if (cs_a[idx(v, h)] == 1'b0) c++;
    return c;
  endfunction

  function automatic int unsigned de_in_line(input int unsigned v);
    int unsigned c = 0;
    for (int h = 0; h < HT; h++) if (de_a[idx(v, h)] == 1'b1) c++;
    return c;
  endfunction

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) step();
    check_eq("rst_csync", csync, 1);
    check_eq("rst_rgb", {r, g, b}, 0);
    check_eq("rst_flags", {dark, shadow, de}, 0);
    check_eq("rst_frame", frame_ctr, 0);

    // Enable while still in reset must stay idle
    en = 1'b1;
    step();
    check_eq("rst_en_csync", csync, 1);
    rst = 1'b0;

    // Capture one frame: sample n is the output for counter index n
    sh_cnt = 0;
    for (int n = 0; n < FRAME; n++) begin
      step();
      cs_a[n]  = csync;
      de_a[n]  = de;
      dk_a[n]  = dark;
      rgb_a[n] = {r, g, b};
      if (shadow) sh_cnt++;
      if (n == FRAME - 2) check_eq("frame_before_wrap", frame_ctr, 0);
    end
    check_eq("frame_after_wrap", frame_ctr, 1);
    check_eq("shadow_zero", sh_cnt, 0);

    edges = 0;
    for (int n = 0; n < FRAME; n++) begin
      if (cs_a[n] == 1'b0 && (n == 0 || cs_a[n-1] == 1'b1)) edges++;
    end
`ifdef NEOGEO_CSYNC_EQU_EN
    check_eq("fall_edges", edges, 49);
    check_eq("pre_equ_low", low_in_line(0), 28);
    check_eq("vsync_low", low_in_line(3), 326);
    check_eq("post_equ_low", low_in_line(8), 28);
    check_eq("vs_h162", cs_a[idx(3, 162)], 0);
    check_eq("vs_h163", cs_a[idx(3, 163)], 1);
    check_eq("vs_h191", cs_a[idx(3, 191)], 1);
    check_eq("vs_h192", cs_a[idx(3, 192)], 0);
    check_eq("eq_h13", cs_a[idx(0, 13)], 0);
    check_eq("eq_h14", cs_a[idx(0, 14)], 1);
    check_eq("eq_h192", cs_a[idx(0, 192)], 0);
    check_eq("eq_h206", cs_a[idx(0, 206)], 1);
`else
    check_eq("fall_edges", edges, 40);
    check_eq("pre_equ_low", low_in_line(0), 29);
    check_eq("vsync_low", low_in_line(3), 355);
    check_eq("post_equ_low", low_in_line(8), 29);
    check_eq("vs_h163", cs_a[idx(3, 163)], 0);
    check_eq("vs_h192", cs_a[idx(3, 192)], 0);
    check_eq("eq_h192", cs_a[idx(0, 192)], 1);
`endif
    check_eq("vs_h354", cs_a[idx(3, 354)], 0);
    check_eq("vs_h355", cs_a[idx(3, 355)], 1);
    check_eq("norm_low", low_in_line(20), 29);
    check_eq("norm_h0", cs_a[idx(20, 0)], 0);
    check_eq("norm_h28", cs_a[idx(20, 28)], 0);
    check_eq("norm_h29", cs_a[idx(20, 29)], 1);

    // Active region
    de_total = 0;
    de_lines = 0;
    for (int v = 0; v < VT; v++) begin
      cnt = de_in_line(v);
      de_total += cnt;
      if (cnt != 0) de_lines++;
    end
    check_eq("de_line_len", de_in_line(20), 320);
    check_eq("de_lines", de_lines, 24);
    check_eq("de_total", de_total, 24 * 320);
    check_eq("de_h56", de_a[idx(20, 56)], 0);
    check_eq("de_h57", de_a[idx(20, 57)], 1);
    check_eq("de_h376", de_a[idx(20, 376)], 1);
    check_eq("de_h377", de_a[idx(20, 377)], 0);
    check_eq("de_v10", de_a[idx(10, 100)], 0);
    check_eq("de_v11", de_a[idx(11, 100)], 1);
    check_eq("de_v34", de_a[idx(34, 100)], 1);
    check_eq("de_v35", de_a[idx(35, 100)], 0);

    // Pattern and dark flag
    check_eq("pix_x0", rgb_a[idx(11, 57)], 15'h7FFF);
    check_eq("pix_x39", rgb_a[idx(11, 96)], 15'h7FFF);
    check_eq("pix_x40", rgb_a[idx(11, 97)], 15'h7FE0);
    check_eq("pix_x80", rgb_a[idx(11, 137)], 15'h03FF);
    check_eq("pix_x319", rgb_a[idx(11, 376)], 15'h0000);
    check_eq("pix_blank", rgb_a[idx(11, 56)], 15'h0000);
    check_eq("dark_y11", dk_a[idx(22, 57)], 0);
    check_eq("dark_y12", dk_a[idx(23, 57)], 1);
    check_eq("dark_blank", dk_a[idx(23, 56)], 0);

    // Abort mid-frame at v=30, h=100 of the second frame
    repeat (30 * HT + 100) step();
    check_eq("pre_dis_de", de, 1);
    en = 1'b0;
    step();
    check_eq("dis_csync", csync, 1);
    check_eq("dis_de", de, 0);
    check_eq("dis_rgb", {r, g, b}, 0);
    repeat (9) step();
    check_eq("dis_hold_csync", csync, 1);
    check_eq("dis_frame", frame_ctr, 1);

    en = 1'b1;
    step();
    check_eq("reen_fall", csync, 0);
    check_eq("reen_de", de, 0);
    repeat (2 * HT + 354) step();
    check_eq("reen_v2_h354", csync, 1);
    repeat (HT) step();
    check_eq("reen_v3_h354", csync, 0);
    check_eq("reen_frame", frame_ctr, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
